mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for a single-port DEPTH x WIDTH memory array. The array is held internally; it is uninitialised and never reset.
- Supports word reads, full-word writes and partial-field writes of the form mem[addr][base +: len].
- Partial writes are done as an internal read-modify-write (RMW) sequence.
- Sits between two pipeline clients and the storage they share. Returns one tagged response per accepted request.

Parameters:
- WIDTH, 8, word width in bits (>=2).
- DEPTH, 16, number of words (power of 2).
- AW, $clog2(DEPTH), address width (derived).
- BW, $clog2(WIDTH), field base width (derived).
- LW, $clog2(WIDTH)+1, field length width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; a request is accepted when valid&ready.
- req_we  in  2  1 = write, 0 = read.
- req_addr  in  2*AW  word address; requester i uses slice [i*AW +: AW].
- req_base  in  2*BW  field LSB position for writes.
- req_len  in  2*LW  field length for writes.
- req_wdata  in  2*WIDTH  write data, right-aligned (bit 0 = field LSB).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  1  requester index of the response.
- rsp_data  out  WIDTH  read data; 0 for write acknowledgements.
- busy  out  1  high while in the RMW state.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0. Memory contents are untouched.
- Reset mid-RMW aborts the pending write: no array update and no response.
- States: IDLE and RMW.
- Arbitration (IDLE only):
  - grant = the single valid requester; if both are valid, grant = rr_ptr.
  - req_ready[grant]=1 combinationally; req_ready is all-zero in RMW and while rst is high.
  - After each accept, rr_ptr <= ~grant.
- Read accepted: rsp_valid=1 the next cycle, with rsp_id=grant and rsp_data = mem[addr] as of the accept edge. Latency 1. Stay in IDLE, so back-to-back reads run 1 per cycle.
- Full write accepted (base==0 and len>=WIDTH): array written at the accept edge; ack (rsp_valid=1, rsp_data=0) the next cycle; stay in IDLE.
- Partial write accepted (any other base/len):
  - Latch id, addr, base, len and wdata; go to RMW with busy=1.
  - During RMW: old = mem[addr]; mask bit k = 1 iff base<=k<base+len and k<WIDTH; new = (old & ~mask) | ((wdata<<base) & mask); array written at the end of the RMW cycle.
  - Ack the next cycle, then return to IDLE. Occupancy 2 cycles, latency 2.
- len==0: zero mask, so no array change, but the full RMW path and ack still occur.
- base+len>WIDTH: the mask clips at WIDTH-1 and out-of-range bits are dropped silently. len>WIDTH saturates to WIDTH.
- wdata bits at positions >= len are ignored.
- Ordering: a write is visible to any read accepted in a later cycle. Responses are returned in acceptance order; at most one response per cycle.
- A requester that drops valid before ready is not accepted; arbitration is re-evaluated every IDLE cycle.
- addr is always in range (DEPTH is a power of 2), so there is no address wrap handling.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins contention and rr_ptr is removed; requester 1 may starve.
- Undefined: round-robin arbitration as specified above.

Test Plan:
- Reset then idle: after rst deassert with no valid -> req_ready=00, rsp_valid=0, busy=0 for 5 cycles.
- R0 full write addr=3 data=0xA5, then R0 read addr=3 -> ack rsp_id=0 data=0; next cycle rsp_data=0xA5 rsp_id=0. The read is accepted one cycle after the write.
- Partial write on mem[5]=0xFF (set by a full write): R1 base=2 len=3 wdata=0x0 -> busy=1 for 1 cycle, ack at cycle+2; a subsequent read of addr 5 returns 0xE3.
- Clipped field on mem[7]=0x00: base=6 len=4 wdata=0xF -> read returns 0xC0; len=0 -> read unchanged and an ack is still issued.
- Contention: both requesters read every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1 and rsp_id follows. With MEM_ARB_FIXED_PRIO_EN defined, all 6 grants go to 0.
- rst asserted during RMW (partial write to addr 9, prior value 0x11) -> no rsp_valid; after reset, a read of addr 9 returns 0x11.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between two pipeline clients and mem_port_arbiter.
//   req_valid/req_ready/req_we : per-requester handshake and direction (bit i = requester i)
//   req_addr/req_base/req_len/req_wdata : per-requester slices [i*W +: W]
//   rsp_valid/rsp_id/rsp_data  : single shared response strobe, requester tag, read data
//   busy                       : arbiter is in its read-modify-write cycle
interface mem_port_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned LW = $clog2(WIDTH) + 1;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_we;
  logic [2*AW-1:0]    req_addr;
  logic [2*BW-1:0]    req_base;
  logic [2*LW-1:0]    req_len;
  logic [2*WIDTH-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_base, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_base, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port DEPTH x WIDTH memory.
// Reads and full-word writes complete in IDLE with one-cycle latency; partial
// field writes (mem[addr][base +: len]) run an internal read-modify-write cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (array contents are not reset)
//   bus  - mem_port_arbiter_if.slave: request handshake/payload, tagged response, busy
// Build option:
//   MEM_ARB_FIXED_PRIO_EN - requester 0 always wins contention (no round-robin pointer)
module mem_port_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned LW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, RMW} state_t;

  state_t           state;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic             rr_ptr;
`endif
  logic [WIDTH-1:0] mem [DEPTH];

  // Partial-write context latched at accept
  logic             l_id;
  logic [AW-1:0]    l_addr;
  logic [BW-1:0]    l_base;
  logic [LW-1:0]    l_len;
  logic [WIDTH-1:0] l_wdata;

  logic             grant_c;
  logic             accept_c;
  logic             sel_we_c;
  logic [AW-1:0]    sel_addr_c;
  logic [BW-1:0]    sel_base_c;
  logic [LW-1:0]    sel_len_c;
  logic [WIDTH-1:0] sel_wdata_c;
  logic             full_c;
  logic [WIDTH-1:0] mask_c;
  logic [WIDTH-1:0] rmw_data_c;
  logic             mem_we_c;
  logic [AW-1:0]    mem_waddr_c;
  logic [WIDTH-1:0] mem_wdata_c;

  // Grant selection and request-field mux
  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    grant_c = ~bus.req_valid[0];
`else
    // Lone requester wins outright; contention goes to rr_ptr
    if (&bus.req_valid) grant_c = rr_ptr;
    else                grant_c = ~bus.req_valid[0];
`endif
    accept_c      = (state == IDLE) && (|bus.req_valid) && !rst;
    bus.req_ready = accept_c ? (grant_c ? 2'b10 : 2'b01) : 2'b00;

    sel_we_c    = grant_c ? bus.req_we[1]                  : bus.req_we[0];
    sel_addr_c  = grant_c ? bus.req_addr[2*AW-1:AW]        : bus.req_addr[AW-1:0];
    sel_base_c  = grant_c ? bus.req_base[2*BW-1:BW]        : bus.req_base[BW-1:0];
    sel_len_c   = grant_c ? bus.req_len[2*LW-1:LW]         : bus.req_len[LW-1:0];
    sel_wdata_c = grant_c ? bus.req_wdata[2*WIDTH-1:WIDTH] : bus.req_wdata[WIDTH-1:0];
    full_c      = (sel_base_c == '0) && (32'(sel_len_c) >= WIDTH);
  end

  // Field mask and merged RMW word; bits at or above WIDTH fall off naturally
  always_comb begin
    mask_c = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      mask_c[k] = (k >= 32'(l_base)) && (k < 32'(l_base) + 32'(l_len));
    end
    rmw_data_c = (mem[l_addr] & ~mask_c) | ((l_wdata << l_base) & mask_c);
  end

  // Array write port: RMW commit or full-word write at accept
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = sel_addr_c;
    mem_wdata_c = sel_wdata_c;
    if (state == RMW && !rst) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = l_addr;
      mem_wdata_c = rmw_data_c;
    end else if (accept_c && sel_we_c && full_c) begin
      mem_we_c = 1'b1;
    end
  end

  // Storage is deliberately left without reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  // Sequencer state, response and latched context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr        <= 1'b0;
`endif
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.busy      <= 1'b0;
      l_id          <= 1'b0;
      l_addr        <= '0;
      l_base        <= '0;
      l_len         <= '0;
      l_wdata       <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr <= ~grant_c;
`endif
            if (!sel_we_c || full_c) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_id    <= grant_c;
              bus.rsp_data  <= sel_we_c ? '0 : mem[sel_addr_c];
            end else begin
              state    <= RMW;
              bus.busy <= 1'b1;
              l_id     <= grant_c;
              l_addr   <= sel_addr_c;
              l_base   <= sel_base_c;
              l_len    <= sel_len_c;
              l_wdata  <= sel_wdata_c;
            end
          end
        end
        RMW: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_id    <= l_id;
          bus.rsp_data  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
